serial_uart_bridge: RTL and testbench

//  Far end of the processor's serial byte port. Bridges that port to an 8N1 UART pin pair.

---
 rtl/serial_uart_bridge_pkg.sv | 14 +
 rtl/serial_fifo.sv | 63 ++++++
 rtl/serial_uart_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_uart_bridge_pkg.sv
// Shared definitions for the serial UART bridge: FSM encodings, frame width and line levels.
package serial_uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } serial_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_fifo.sv
// First-word-fall-through FIFO with full/empty/count; a pop makes room for a push in the same cycle.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  // Head reads as zero while empty so the consumer never sees stale data.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Bridges the processor's serial byte port to an 8N1 UART pin pair through a TX FIFO and an RX FIFO.
module serial_uart_bridge
  import serial_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] cpu_tx_data,
  input  logic                 cpu_tx_wren,
  output logic                 cpu_tx_ready,
  output logic [DATA_BITS-1:0] cpu_rx_data,
  output logic                 cpu_rx_valid,
  input  logic                 cpu_rx_rden,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic                 rx_overrun,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 rx_full, rx_empty, rx_push;
  logic                 unused_counts;

  assign tx_push       = cpu_tx_wren && !tx_full;
  assign cpu_tx_ready  = !tx_full;
  assign cpu_rx_valid  = !rx_empty;
  assign unused_counts = ^{tx_count, rx_count};

  serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset),
    .push(tx_push), .push_data(cpu_tx_data),
    .pop(tx_pop), .pop_data(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // ---------------- transmitter ----------------
  serial_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;

  assign uart_txd = txd_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= LINE_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_idx_q == IDX_LAST) tx_state_d = ST_STOP;
          else                      tx_idx_d   = tx_idx_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        // A queued byte chains straight into the next start bit.
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_cnt_d   = BIT_LAST;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d = LINE_IDLE;
    unique case (tx_state_q)
      ST_START: txd_d = !LINE_IDLE;
      ST_DATA:  txd_d = tx_shift_q[0];
      default:  txd_d = LINE_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  serial_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d, rxd_prev_q, rxd_prev_d;
  logic                 rx_overrun_q, rx_overrun_d, rx_frame_err_q, rx_frame_err_d;
  logic                 rx_fall, rx_stop_sample;

  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset),
    .push(rx_push), .push_data(rx_shift_q),
    .pop(cpu_rx_rden), .pop_data(cpu_rx_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // The synchroniser keeps tracking the line through reset, so a line held low
  // across reset shows no 1->0 transition afterwards.
  always_comb begin
    rxd_meta_d = uart_rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
  end

  always_ff @(posedge clock) begin
    rxd_meta_q <= rxd_meta_d;
    rxd_sync_q <= rxd_sync_d;
    rxd_prev_q <= rxd_prev_d;
  end

  assign rx_fall = (rxd_prev_q == LINE_IDLE) && (rxd_sync_q != LINE_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state_q     <= ST_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (rxd_sync_q == LINE_IDLE) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_cnt_d   = BIT_LAST;
            rx_idx_d   = '0;
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == IDX_LAST) rx_state_d = ST_STOP;
          else                      rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == '0) rx_state_d = ST_IDLE;
        else                rx_cnt_d   = rx_cnt_q - CNT_W'(1);
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_sample = (rx_state_q == ST_STOP) && (rx_cnt_q == '0);
    rx_push        = rx_stop_sample && (rxd_sync_q == LINE_IDLE);
    rx_overrun_d   = rx_overrun_q || (rx_push && rx_full && !cpu_rx_rden);
    rx_frame_err_d = rx_frame_err_q || (rx_stop_sample && (rxd_sync_q != LINE_IDLE));
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed plus randomized bench for serial_uart_bridge with a byte-level UART/FIFO reference model.
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cpu_tx_data = 8'h00;
  logic       cpu_tx_wren = 1'b0;
  logic       cpu_tx_ready;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_valid;
  logic       cpu_rx_rden = 1'b0;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_seen_q[$];
  int         tx_start_q[$];
  int         tx_bad_stop = 0;
  int         tx_base = 0;
  logic [7:0] rx_model_q[$];
  logic       model_overrun = 1'b0;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_tx_data(cpu_tx_data), .cpu_tx_wren(cpu_tx_wren), .cpu_tx_ready(cpu_tx_ready),
    .cpu_rx_data(cpu_rx_data), .cpu_rx_valid(cpu_rx_valid), .cpu_rx_rden(cpu_rx_rden),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- line monitor: decodes uart_txd frames ----------------
  logic       mon_prev = 1'b1;
  logic [7:0] mon_byte;
  int         mon_t;
  initial begin
    forever begin
      @(negedge clock);
      if (reset && mon_prev && !uart_txd) begin
        mon_t = cyc;
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          mon_byte[i] = uart_txd;
        end
        repeat (CPB) @(negedge clock);
        if (!uart_txd) tx_bad_stop++;
        tx_seen_q.push_back(mon_byte);
        tx_start_q.push_back(mon_t);
      end
      mon_prev = uart_txd;
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write_byte(input logic [7:0] b);
    cpu_tx_data = b;
    cpu_tx_wren = 1'b1;
    @(negedge clock);
    cpu_tx_wren = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = frame[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    drive_rx(b, 1'b1);
    idle(2 * CPB);
    if (rx_model_q.size() < DEPTH) rx_model_q.push_back(b);
    else                           model_overrun = 1'b1;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    e = rx_model_q.pop_front();
    check({tag, "_valid"}, cpu_rx_valid, 1);
    check({tag, "_data"}, cpu_rx_data, e);
    cpu_rx_rden = 1'b1;
    @(negedge clock);
    cpu_rx_rden = 1'b0;
  endtask

  task automatic score_tx(input string tag);
    int n;
    logic [31:0] obs;
    n = 0;
    while (tx_seen_q.size() < tx_base + exp_q.size() && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, n < 2000, 1);
    while (exp_q.size() > 0) begin
      obs = (tx_base < tx_seen_q.size()) ? {24'h0, tx_seen_q[tx_base]} : 32'hFFFF_FFFF;
      check({tag, "_byte"}, obs, {24'h0, exp_q.pop_front()});
      tx_base++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] frame;
    logic [7:0] b;
    int         first_start;
    int         n;
    int         lows;

    reset = 1'b0;
    idle(4);
    check("reset_txd", uart_txd, 1);
    check("reset_tx_ready", cpu_tx_ready, 1);
    check("reset_rx_valid", cpu_rx_valid, 0);
    check("reset_rx_data", cpu_rx_data, 0);
    check("reset_overrun", rx_overrun, 0);
    check("reset_frame_err", rx_frame_err, 0);
    reset = 1'b1;
    idle(2);

    // Single byte: line low two edges after the write, then LSB-first data and stop.
    write_byte(8'h55);
    exp_q.push_back(8'h55);
    check("tx_idle_after_write", uart_txd, 1);
    idle(1);
    check("tx_idle_n1", uart_txd, 1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        idle(1);
        check("tx_frame_55", uart_txd, frame[i]);
        check("tx_ready_55", cpu_tx_ready, 1);
      end
    end
    score_tx("tx_single");
    idle(2 * CPB);

    // Burst of six: the shifter takes the first, FIFO absorbs DEPTH more, last is dropped.
    first_start = tx_start_q.size();
    for (int i = 0; i < 6; i++) begin
      b = 8'h41 + 8'(i);
      cpu_tx_data = b;
      cpu_tx_wren = 1'b1;
      check("tx_ready_burst", cpu_tx_ready, (i <= DEPTH) ? 1 : 0);
      if (i <= DEPTH) exp_q.push_back(b);
      @(negedge clock);
    end
    cpu_tx_wren = 1'b0;
    score_tx("tx_burst");
    for (int k = 0; k < DEPTH; k++) begin
      n = (first_start + k + 1 < tx_start_q.size()) ?
          tx_start_q[first_start + k + 1] - tx_start_q[first_start + k] : -1;
      check("tx_back_to_back_gap", n, 10 * CPB);
    end
    idle(2 * CPB);

    // Random TX bytes written whenever the bridge is ready.
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!cpu_tx_ready && n < 200) begin
        idle(1);
        n++;
      end
      check("tx_ready_wait", cpu_tx_ready, 1);
      b = 8'($urandom_range(0, 255));
      write_byte(b);
      exp_q.push_back(b);
      idle($urandom_range(0, 12));
    end
    score_tx("tx_random");
    check("tx_stop_bits", tx_bad_stop, 0);
    idle(4 * CPB);

    // Single RX byte and pop.
    send_frame(8'hA3);
    read_check("rx_a3");
    check("rx_empty_after_pop", cpu_rx_valid, 0);

    // Overfill: DEPTH bytes kept, the next one dropped with overrun.
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i));
      check("rx_overrun_fill", rx_overrun, model_overrun);
    end
    for (int i = 0; i < DEPTH; i++) read_check("rx_fill_read");
    check("rx_empty_after_drain", cpu_rx_valid, 0);

    // One-clock glitch is ignored without a flag.
    uart_rxd = 1'b0;
    idle(1);
    uart_rxd = 1'b1;
    idle(4 * CPB);
    check("glitch_valid", cpu_rx_valid, 0);
    check("glitch_frame_err", rx_frame_err, 0);

    // Low stop bit: byte dropped, frame error set.
    drive_rx(8'h5A, 1'b0);
    idle(2 * CPB);
    check("frame_err_set", rx_frame_err, 1);
    check("frame_err_no_push", cpu_rx_valid, 0);
    check("overrun_sticky", rx_overrun, 1);

    // Random RX traffic with interleaved reads.
    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1 && rx_model_q.size() > 0) read_check("rx_random");
    end
    while (rx_model_q.size() > 0) read_check("rx_random_drain");
    check("rx_random_empty", cpu_rx_valid, 0);

    // Reset mid-frame: TX in data bit 3, two bytes queued, one RX byte pending.
    send_frame(8'($urandom_range(0, 255)));
    check("pre_reset_rx_valid", cpu_rx_valid, 1);
    b = 8'($urandom_range(0, 255));
    write_byte(b);
    write_byte(8'($urandom_range(0, 255)));
    write_byte(8'($urandom_range(0, 255)));
    idle(16);
    check("pre_reset_tx_bit3", uart_txd, b[3]);
    reset = 1'b0;
    idle(1);
    check("midreset_txd", uart_txd, 1);
    check("midreset_tx_ready", cpu_tx_ready, 1);
    check("midreset_rx_valid", cpu_rx_valid, 0);
    check("midreset_rx_data", cpu_rx_data, 0);
    check("midreset_overrun", rx_overrun, 0);
    check("midreset_frame_err", rx_frame_err, 0);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 30 * CPB; c++) begin
      idle(1);
      if (!uart_txd) lows++;
    end
    check("post_reset_tx_quiet", lows, 0);
    check("post_reset_rx_valid", cpu_rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
